// File: rtl/ahb_led_seq_pkg.sv
// Shared types and constants for the AHB-Lite LED pattern sequencer.
// Holds the sequencer FSM encoding, the register map offsets and the CTRL bit layout.
package ahb_led_seq_pkg;

   localparam int unsigned PRE_W = 24;
   localparam int unsigned NSTEP = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_MANVAL   = 3'd1;
   localparam logic [2:0] OFF_PRESCALE = 3'd2;
   localparam logic [2:0] OFF_STATUS   = 3'd3;
   localparam logic [2:0] OFF_PAT0     = 3'd4;

   localparam int unsigned CTRL_EN_BIT      = 0;
   localparam int unsigned CTRL_ONESHOT_BIT = 1;
   localparam int unsigned CTRL_MANUAL_BIT  = 2;
   localparam int unsigned CTRL_LEN_LSB     = 4;

   typedef struct packed {
      logic [1:0] len;
      logic       manual;
      logic       oneshot;
      logic       en;
   } ctrl_t;

   function automatic logic [31:0] ctrl_pack(input ctrl_t c);
      return {26'd0, c.len, 1'b0, c.manual, c.oneshot, c.en};
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..prescale while enabled and flags the terminal count.
// Clearing (or disabling) forces the count back to zero and suppresses the tick.
module led_tick_gen #(
   parameter int unsigned PRE_W = ahb_led_seq_pkg::PRE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [PRE_W-1:0] prescale,
   output logic             tick
);

   logic [PRE_W-1:0] cnt_q;
   logic [PRE_W-1:0] cnt_d;

   assign tick = en & ~clr & (cnt_q == prescale);

   // Next count: wrap on tick, hold at zero whenever cleared or idle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr || !en) begin
         cnt_d = {PRE_W{1'b0}};
      end else if (tick) begin
         cnt_d = {PRE_W{1'b0}};
      end else begin
         cnt_d = cnt_q + PRE_W'(1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= {PRE_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ahb_led_seq.sv
// AHB-Lite slave that steps an 8-bit LED output through up to four patterns.
// Zero-wait-state register file, IDLE/RUN/DONE sequencer and a registered LED driver.
module ahb_led_seq #(
   parameter int unsigned PRE_W = ahb_led_seq_pkg::PRE_W,
   parameter int unsigned NSTEP = ahb_led_seq_pkg::NSTEP
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic        HREADY,
   input  logic        HWRITE,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic [7:0]  LED
);
   import ahb_led_seq_pkg::*;

   logic             sel_q, sel_d;
   logic             wr_q, wr_d;
   logic [2:0]       addr_q, addr_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic [7:0]       manval_q, manval_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [7:0]       pat_q [NSTEP];
   logic [7:0]       pat_d [NSTEP];
   state_e           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [7:0]       led_q, led_d;

   logic             wr_en_s;
   logic             restart_s;
   logic             tick_s;
   logic             last_s;
   logic             unused_s;

   assign unused_s  = ^{HSIZE, HTRANS[0], HADDR[31:5], HADDR[1:0], HWDATA[31:24]};
   assign HREADYOUT = 1'b1;
   assign LED       = led_q;

   // A CTRL or PRESCALE write restarts the sequence and beats any coincident tick.
   assign wr_en_s   = sel_q & wr_q & HREADY;
   assign restart_s = wr_en_s & ((addr_q == OFF_CTRL) | (addr_q == OFF_PRESCALE));
   assign last_s    = (idx_q == ctrl_q.len);

   led_tick_gen #(.PRE_W(PRE_W)) u_tick (
      .clk      (HCLK),
      .rst_n    (HRESETn),
      .clr      (restart_s),
      .en       (state_q == ST_RUN),
      .prescale (pre_q),
      .tick     (tick_s)
   );

   always_comb begin
      sel_d  = sel_q;
      wr_d   = wr_q;
      addr_d = addr_q;
      if (HREADY) begin
         sel_d  = HSEL & HTRANS[1];
         wr_d   = HWRITE;
         addr_d = HADDR[4:2];
      end else begin
         sel_d  = sel_q;
         wr_d   = wr_q;
         addr_d = addr_q;
      end
   end

   always_comb begin
      ctrl_d   = ctrl_q;
      manval_d = manval_q;
      pre_d    = pre_q;
      pat_d    = pat_q;
      if (wr_en_s) begin
         case (addr_q)
            OFF_CTRL: begin
               ctrl_d.en      = HWDATA[CTRL_EN_BIT];
               ctrl_d.oneshot = HWDATA[CTRL_ONESHOT_BIT];
               ctrl_d.manual  = HWDATA[CTRL_MANUAL_BIT];
               ctrl_d.len     = HWDATA[CTRL_LEN_LSB +: 2];
            end
            OFF_MANVAL:   manval_d = HWDATA[7:0];
            OFF_PRESCALE: pre_d    = HWDATA[PRE_W-1:0];
            OFF_STATUS:   ctrl_d   = ctrl_q;
            default:      pat_d[addr_q[1:0]] = HWDATA[7:0];
         endcase
      end else begin
         ctrl_d = ctrl_q;
      end
   end

   // Next state looks at the incoming CTRL value so enable/disable act on the write edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_d.en) state_d = ST_RUN;
            else           state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (!ctrl_d.en)                          state_d = ST_IDLE;
            else if (restart_s)                      state_d = ST_RUN;
            else if (tick_s && last_s && ctrl_q.oneshot) state_d = ST_DONE;
            else                                     state_d = ST_RUN;
         end
         ST_DONE: begin
            if (!ctrl_d.en)     state_d = ST_IDLE;
            else if (restart_s) state_d = ST_RUN;
            else                state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      idx_d = idx_q;
      if (restart_s) begin
         idx_d = 2'd0;
      end else if ((state_q == ST_RUN) && tick_s) begin
         if (!last_s)              idx_d = idx_q + 2'd1;
         else if (!ctrl_q.oneshot) idx_d = 2'd0;
         else                      idx_d = idx_q;
      end else begin
         idx_d = idx_q;
      end
   end

   always_comb begin
      led_d = 8'h00;
      if (ctrl_q.manual)           led_d = manval_q;
      else if (state_q == ST_IDLE) led_d = 8'h00;
      else                         led_d = pat_q[idx_q];
   end

   always_comb begin
      HRDATA = 32'h0000_0000;
      case (addr_q)
         OFF_CTRL:     HRDATA = ctrl_pack(ctrl_q);
         OFF_MANVAL:   HRDATA = {24'h00_0000, manval_q};
         OFF_PRESCALE: HRDATA = 32'(pre_q);
         OFF_STATUS:   HRDATA = {28'h000_0000, idx_q, state_q == ST_DONE, state_q == ST_RUN};
         default:      HRDATA = {24'h00_0000, pat_q[addr_q[1:0]]};
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         sel_q    <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= 3'd0;
         ctrl_q   <= '{len: 2'd0, manual: 1'b0, oneshot: 1'b0, en: 1'b0};
         manval_q <= 8'h00;
         pre_q    <= {PRE_W{1'b0}};
         for (int i = 0; i < NSTEP; i++) begin
            pat_q[i] <= 8'h00;
         end
         state_q  <= ST_IDLE;
         idx_q    <= 2'd0;
         led_q    <= 8'h00;
      end else begin
         sel_q    <= sel_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         ctrl_q   <= ctrl_d;
         manval_q <= manval_d;
         pre_q    <= pre_d;
         pat_q    <= pat_d;
         state_q  <= state_d;
         idx_q    <= idx_d;
         led_q    <= led_d;
      end
   end

endmodule

// File: tb/tb_ahb_led_seq.sv
// Directed and randomized bench for ahb_led_seq with a time-based reference model.
module tb_ahb_led_seq;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL = 1'b0;
   logic        HREADY = 1'b1;
   logic        HWRITE = 1'b0;
   logic [1:0]  HTRANS = 2'b00;
   logic [2:0]  HSIZE = 3'b010;
   logic [31:0] HADDR = 32'h0;
   logic [31:0] HWDATA = 32'h0;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic [7:0]  LED;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int e_cyc = 0;

   // Reference model: register contents plus the edge count of the last restart.
   logic       m_en, m_one, m_man;
   int         m_len, m_pre;
   logic [7:0] m_manval;
   logic [7:0] m_pat [4];

   ahb_led_seq dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
      .HTRANS(HTRANS), .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .LED(LED)
   );

   always #5 HCLK = ~HCLK;

   task automatic step();
      @(posedge HCLK);
      cyc++;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 1'b0; m_one = 1'b0; m_man = 1'b0;
      m_len = 0; m_pre = 0; m_manval = 8'h00;
      for (int i = 0; i < 4; i++) m_pat[i] = 8'h00;
      e_cyc = cyc;
   endtask

   // STATUS t edges after the last restart: one step is PRESCALE+1 edges.
   function automatic logic [31:0] m_status(input int t);
      int s;
      if (!m_en) return 32'h0;
      s = t / (m_pre + 1);
      if (m_one) begin
         if (s > m_len) return {28'd0, m_len[1:0], 2'b10};
         else           return {28'd0, s[1:0], 2'b01};
      end
      s = s % (m_len + 1);
      return {28'd0, s[1:0], 2'b01};
   endfunction

   // LED trails the sequencer position by one edge.
   function automatic logic [7:0] m_led(input int t);
      int s;
      if (m_man) return m_manval;
      if (!m_en) return 8'h00;
      s = (t - 1) / (m_pre + 1);
      if (m_one) s = (s > m_len) ? m_len : s;
      else       s = s % (m_len + 1);
      return m_pat[s];
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a, input int t);
      case (a)
         3'd0:    return {26'd0, m_len[1:0], 1'b0, m_man, m_one, m_en};
         3'd1:    return {24'd0, m_manval};
         3'd2:    return {8'd0, m_pre[23:0]};
         3'd3:    return m_status(t);
         default: return {24'd0, m_pat[a[1:0]]};
      endcase
   endfunction

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
      HADDR = ($urandom() & 32'hFFFF_FFE0) | {27'd0, a, 2'b00} | 32'($urandom_range(0, 3));
      HWDATA = 32'h0;
      step();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
      step();
      case (a)
         3'd0: begin
            m_en = d[0]; m_one = d[1]; m_man = d[2]; m_len = int'(d[5:4]); e_cyc = cyc;
         end
         3'd1: m_manval = d[7:0];
         3'd2: begin m_pre = int'(d[23:0]); e_cyc = cyc; end
         3'd3: m_en = m_en;
         default: m_pat[a[1:0]] = d[7:0];
      endcase
   endtask

   task automatic read_chk(input string tag, input logic [2:0] a);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {27'd0, a, 2'b00};
      step();
      HSEL = 1'b0; HTRANS = 2'b00;
      chk(tag, HRDATA, m_read(a, cyc - e_cyc));
   endtask

   task automatic run_leds(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         chk(tag, {24'd0, LED}, {24'd0, m_led(cyc - e_cyc)});
      end
   endtask

   initial begin
      logic [31:0] ctrl;
      int len, pre;

      // Reset state
      model_reset();
      step();
      chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
      step();
      chk("rst_led", {24'd0, LED}, 32'h0);
      chk("rst_hrdata", HRDATA, 32'h0);
      HRESETn = 1'b1;
      for (int a = 0; a < 8; a++) read_chk("rst_read", 3'(a));

      // Looping sequence, four patterns, step every 4 cycles
      bus_write(3'd4, 32'h01); bus_write(3'd5, 32'h02);
      bus_write(3'd6, 32'h04); bus_write(3'd7, 32'h08);
      bus_write(3'd2, 32'd3);
      bus_write(3'd0, 32'h31);
      run_leds("loop_led", 18);
      chk("loop_led_wrap", {24'd0, LED}, 32'h01);
      read_chk("loop_status", 3'd3);
      chk("loop_busy", {31'd0, HRDATA[0]}, 32'd1);
      read_chk("loop_ctrl", 3'd0);
      read_chk("loop_prescale", 3'd2);
      read_chk("loop_pat2", 3'd6);

      // Non-transfer with HSEL high must not write
      HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h4;
      step();
      HSEL = 1'b0; HWRITE = 1'b0; HWDATA = 32'hFF;
      step();
      read_chk("idle_trans_nowrite", 3'd1);

      // One-shot, two steps, tick every cycle
      bus_write(3'd0, 32'h0);
      bus_write(3'd2, 32'd0);
      bus_write(3'd0, 32'h13);
      run_leds("oneshot_led", 6);
      chk("oneshot_hold", {24'd0, LED}, 32'h02);
      read_chk("oneshot_status", 3'd3);
      chk("oneshot_status_val", HRDATA, 32'h06);
      bus_write(3'd0, 32'h0);
      run_leds("stop_led", 2);
      chk("stop_led_zero", {24'd0, LED}, 32'h0);
      read_chk("stop_status", 3'd3);

      // Manual override while running, then back to patterns
      bus_write(3'd1, 32'hA5);
      bus_write(3'd0, 32'h05);
      run_leds("manual_led", 4);
      chk("manual_val", {24'd0, LED}, 32'hA5);
      read_chk("manual_status", 3'd3);
      chk("manual_busy", {31'd0, HRDATA[0]}, 32'd1);
      bus_write(3'd2, 32'd1);
      bus_write(3'd0, 32'h31);
      run_leds("unmanual_led", 10);

      // Restart write landing on a tick cycle
      bus_write(3'd2, 32'd0);
      run_leds("collide_pre", 3);
      bus_write(3'd2, 32'd0);
      step();
      chk("collide_t1", {24'd0, LED}, 32'h01);
      chk("collide_t1_model", {24'd0, LED}, {24'd0, m_led(cyc - e_cyc)});
      step();
      chk("collide_t2", {24'd0, LED}, 32'h02);
      run_leds("collide_run", 4);
      read_chk("collide_status", 3'd3);

      // Mid-run reset at IDX=2
      bus_write(3'd2, 32'd3);
      run_leds("pre_reset_led", 8);
      chk("pre_reset_idx", m_status(cyc - e_cyc), 32'h09);
      HRESETn = 1'b0;
      step();
      HRESETn = 1'b1;
      model_reset();
      chk("midrst_led", {24'd0, LED}, 32'h0);
      chk("midrst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
      for (int a = 0; a < 8; a++) read_chk("midrst_read", 3'(a));
      run_leds("midrst_idle_led", 3);

      // Randomized configurations
      for (int r = 0; r < 8; r++) begin
         bus_write(3'd0, 32'h0);
         for (int p = 0; p < 4; p++) bus_write(3'(4 + p), 32'($urandom_range(0, 255)));
         pre = $urandom_range(0, 4);
         len = $urandom_range(0, 3);
         bus_write(3'd2, 32'(pre));
         ctrl = {26'd0, 2'(len), 3'b000, 1'b1} | {30'd0, 1'($urandom_range(0, 1)), 1'b0};
         bus_write(3'd0, ctrl);
         run_leds("rand_led", (len + 2) * (pre + 1) + 2);
         read_chk("rand_status", 3'd3);
         bus_write(3'(4 + $urandom_range(0, 3)), 32'($urandom_range(0, 255)));
         run_leds("rand_patwr_led", 3);
         read_chk("rand_ctrl", 3'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
